// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with registered write-first reads,
// optional hardwired zero entry and a run-time sequential clear engine.
module regfile_2r1w #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    addr_a,
  output logic [WIDTH-1:0] dout_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    addr_b,
  output logic [WIDTH-1:0] dout_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr_w,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_req,
  output logic             busy,
  output logic             wr_drop
);

  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  dout_a_q, dout_a_d;
  logic [WIDTH-1:0]  dout_b_q, dout_b_d;
  logic              wr_drop_q, wr_drop_d;
  logic              busy_s;
  logic              wr_zero_s;
  logic              wr_ok_s;

  // Read result as seen after this edge's clear/write has landed.
  function automatic logic [WIDTH-1:0] next_rd(
    input logic [AW-1:0]    addr,
    input logic [WIDTH-1:0] stored,
    input logic             clr_hit,
    input logic             wr_hit,
    input logic [WIDTH-1:0] wdata
  );
    logic [WIDTH-1:0] val;
    if (ZERO_REG && (addr == ADDR_ZERO)) begin
      val = {WIDTH{1'b0}};
    end else if (clr_hit) begin
      val = {WIDTH{1'b0}};
    end else if (wr_hit) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  assign busy_s    = (state_q == S_CLEAR);
  assign wr_zero_s = ZERO_REG && (addr_w == ADDR_ZERO);
  assign wr_ok_s   = wr_en && !busy_s && !wr_zero_s;

  assign busy    = busy_s;
  assign wr_drop = wr_drop_q;
  assign dout_a  = dout_a_q;
  assign dout_b  = dout_b_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          ptr_d   = ADDR_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        // ptr wraps back to zero naturally after the last entry
        ptr_d = ptr_q + {{(AW-1){1'b0}}, 1'b1};
        if (ptr_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CLEAR;
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = ADDR_ZERO;
      end
    endcase
  end

  always_comb begin
    dout_a_d  = dout_a_q;
    dout_b_d  = dout_b_q;
    wr_drop_d = wr_en && busy_s && !wr_zero_s;
    if (rd_en_a) begin
      dout_a_d = next_rd(addr_a, mem_q[addr_a], busy_s && (ptr_q == addr_a),
                         wr_ok_s && (addr_w == addr_a), din);
    end else begin
      dout_a_d = dout_a_q;
    end
    if (rd_en_b) begin
      dout_b_d = next_rd(addr_b, mem_q[addr_b], busy_s && (ptr_q == addr_b),
                         wr_ok_s && (addr_w == addr_b), din);
    end else begin
      dout_b_d = dout_b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= ADDR_ZERO;
      dout_a_q  <= {WIDTH{1'b0}};
      dout_b_q  <= {WIDTH{1'b0}};
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      dout_a_q  <= dout_a_d;
      dout_b_q  <= dout_b_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Clear sweep and normal writes never coincide: writes are refused while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (busy_s) begin
        mem_q[ptr_q] <= {WIDTH{1'b0}};
      end else if (wr_ok_s) begin
        mem_q[addr_w] <= din;
      end
    end
  end

endmodule
